affine_sb_seq: RTL

AFFINE_SB_SEQ -- requirements
Module: affine_sb_seq

---
 rtl/affine_sb_seq.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/affine_sb_seq.sv
// Affine sub-block MV sequencer: derives one MV per 4x4 sub-block from control-point MVs.
// Build option AFFINE_6PARAM_EN selects the 6-parameter model; default is 4-parameter.

module affine_recip_rom (
  input  logic [3:0] addr,
  output logic [7:0] data
);
  // R = floor(256 / (W - 1)) for W = 2^(addr+1)
  always_comb begin
    data = 8'd0;
    case (addr)
      4'd1:    data = 8'd85;
      4'd2:    data = 8'd36;
      4'd3:    data = 8'd17;
      4'd4:    data = 8'd8;
      4'd5:    data = 8'd4;
      4'd6:    data = 8'd2;
      default: data = 8'd0;
    endcase
  end
endmodule

module affine_sb_seq (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2:0]         size_code,
  input  logic signed [15:0] mv0x,
  input  logic signed [15:0] mv0y,
  input  logic signed [15:0] mv1x,
  input  logic signed [15:0] mv1y,
  input  logic signed [15:0] mv2x,
  input  logic signed [15:0] mv2y,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4:0]         out_sbx,
  output logic [4:0]         out_sby,
  output logic signed [15:0] out_mvx,
  output logic signed [15:0] out_mvy
);
  localparam int unsigned MW = 16;
  localparam int unsigned GW = 25;
  localparam int unsigned IW = 34;
  localparam int unsigned SW = 5;
  localparam int unsigned RW = 8;
  localparam logic signed [IW-1:0] SAT_HI = IW'(32767);
  localparam logic signed [IW-1:0] SAT_LO = IW'(-32768);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    GRAD   = 3'd2,
    EMIT   = 3'd3,
    DONE   = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [2:0]           sc_q;
  logic signed [MW-1:0] mv0x_q, mv0y_q, mv1x_q, mv1y_q;
  logic [RW-1:0]        r_q, rom_data;
  logic signed [GW-1:0] ghx_q, ghy_q, gvx_q, gvy_q;
  logic signed [GW-1:0] ghx_c, ghy_c, gvx_c, gvy_c;
  logic signed [GW-1:0] r_e, dhx_c, dhy_c;

  logic                 code_ok_c, last_c;
  logic [SW-1:0]        last_idx_c, adv_x_c, adv_y_c;
  logic signed [IW-1:0] xs_c, ys_c, acc_x_c, acc_y_c, sum_x_c, sum_y_c;
  logic signed [MW-1:0] calc_x_c, calc_y_c;

  logic                 busy_nx, done_nx, err_nx, valid_nx;
  logic [SW-1:0]        sbx_nx, sby_nx;
  logic signed [MW-1:0] mvx_nx, mvy_nx;

  function automatic logic signed [MW-1:0] sat16(input logic signed [IW-1:0] v);
    if (v > SAT_HI)      return MW'(SAT_HI);
    else if (v < SAT_LO) return MW'(SAT_LO);
    else                 return MW'(v);
  endfunction

  affine_recip_rom u_rom (
    .addr ({1'b0, sc_q}),
    .data (rom_data)
  );

  assign code_ok_c = (size_code != 3'd0) && (size_code != 3'd7);

`ifdef AFFINE_6PARAM_EN
  logic signed [MW-1:0] mv2x_q, mv2y_q;
  logic signed [GW-1:0] dvx_c, dvy_c;
`else
  logic unused_mv2;
  assign unused_mv2 = ^{mv2x, mv2y};
`endif

  // Gradients from the latched MVs and reciprocal
  always_comb begin
    r_e   = GW'(r_q);
    dhx_c = GW'(mv1x_q) - GW'(mv0x_q);
    dhy_c = GW'(mv1y_q) - GW'(mv0y_q);
    ghx_c = dhx_c * r_e;
    ghy_c = dhy_c * r_e;
`ifdef AFFINE_6PARAM_EN
    dvx_c = GW'(mv2x_q) - GW'(mv0x_q);
    dvy_c = GW'(mv2y_q) - GW'(mv0y_q);
    gvx_c = dvx_c * r_e;
    gvy_c = dvy_c * r_e;
`else
    gvx_c = -ghy_c;
    gvy_c = ghx_c;
`endif
  end

  // Next sub-block index and its MV; before the first beat the index is still (0,0)
  always_comb begin
    case (sc_q)
      3'd2:    last_idx_c = SW'(1);
      3'd3:    last_idx_c = SW'(3);
      3'd4:    last_idx_c = SW'(7);
      3'd5:    last_idx_c = SW'(15);
      3'd6:    last_idx_c = SW'(31);
      default: last_idx_c = SW'(0);
    endcase
    last_c = (out_sbx == last_idx_c) && (out_sby == last_idx_c);
    adv_x_c = out_sbx;
    adv_y_c = out_sby;
    if (out_valid) begin
      if (out_sbx == last_idx_c) begin
        adv_x_c = SW'(0);
        adv_y_c = out_sby + SW'(1);
      end else begin
        adv_x_c = out_sbx + SW'(1);
      end
    end
    xs_c     = IW'({adv_x_c, 2'b00});
    ys_c     = IW'({adv_y_c, 2'b00});
    acc_x_c  = IW'(ghx_q) * xs_c + IW'(gvx_q) * ys_c;
    acc_y_c  = IW'(ghy_q) * xs_c + IW'(gvy_q) * ys_c;
    sum_x_c  = IW'(mv0x_q) + (acc_x_c >>> 8);
    sum_y_c  = IW'(mv0y_q) + (acc_y_c >>> 8);
    calc_x_c = sat16(sum_x_c);
    calc_y_c = sat16(sum_y_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = code_ok_c ? LOOKUP : DONE;
      LOOKUP:  state_nx = GRAD;
      GRAD:    state_nx = EMIT;
      EMIT:    if (out_valid && out_ready && last_c) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    busy_nx  = (state_nx != IDLE);
    done_nx  = (state_nx == DONE);
    err_nx   = 1'b0;
    valid_nx = out_valid;
    sbx_nx   = out_sbx;
    sby_nx   = out_sby;
    mvx_nx   = out_mvx;
    mvy_nx   = out_mvy;
    case (state)
      IDLE: begin
        valid_nx = 1'b0;
        sbx_nx   = SW'(0);
        sby_nx   = SW'(0);
        err_nx   = start && !code_ok_c;
      end
      EMIT: begin
        if (!out_valid || out_ready) begin
          if (out_valid && last_c) begin
            valid_nx = 1'b0;
            sbx_nx   = SW'(0);
            sby_nx   = SW'(0);
          end else begin
            valid_nx = 1'b1;
            sbx_nx   = adv_x_c;
            sby_nx   = adv_y_c;
            mvx_nx   = calc_x_c;
            mvy_nx   = calc_y_c;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sc_q      <= 3'd0;
      mv0x_q    <= '0;
      mv0y_q    <= '0;
      mv1x_q    <= '0;
      mv1y_q    <= '0;
`ifdef AFFINE_6PARAM_EN
      mv2x_q    <= '0;
      mv2y_q    <= '0;
`endif
      r_q       <= '0;
      ghx_q     <= '0;
      ghy_q     <= '0;
      gvx_q     <= '0;
      gvy_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      out_valid <= 1'b0;
      out_sbx   <= '0;
      out_sby   <= '0;
      out_mvx   <= '0;
      out_mvy   <= '0;
    end else begin
      if (state == IDLE && start && code_ok_c) begin
        sc_q   <= size_code;
        mv0x_q <= mv0x;
        mv0y_q <= mv0y;
        mv1x_q <= mv1x;
        mv1y_q <= mv1y;
`ifdef AFFINE_6PARAM_EN
        mv2x_q <= mv2x;
        mv2y_q <= mv2y;
`endif
      end
      if (state == LOOKUP) r_q <= rom_data;
      if (state == GRAD) begin
        ghx_q <= ghx_c;
        ghy_q <= ghy_c;
        gvx_q <= gvx_c;
        gvy_q <= gvy_c;
      end
      busy      <= busy_nx;
      done      <= done_nx;
      err       <= err_nx;
      out_valid <= valid_nx;
      out_sbx   <= sbx_nx;
      out_sby   <= sby_nx;
      out_mvx   <= mvx_nx;
      out_mvy   <= mvy_nx;
    end
  end

endmodule
